// File: rtl/regs_bus_arbiter_pkg.sv
// Shared types and constants for the PWM register-bus arbiter.
// Holds the transaction FSM states, bus widths and register map addresses.
package regs_bus_arbiter_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int REG_DATA_W = 8;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    ACK
  } bus_state_t;

  localparam reg_addr_t ADDR_PERIOD_L     = 6'h00;
  localparam reg_addr_t ADDR_PERIOD_H     = 6'h01;
  localparam reg_addr_t ADDR_DUTY_L       = 6'h02;
  localparam reg_addr_t ADDR_DUTY_H       = 6'h03;
  localparam reg_addr_t ADDR_PRESCALE     = 6'h04;
  localparam reg_addr_t ADDR_CTRL         = 6'h05;
  localparam reg_addr_t ADDR_STATUS       = 6'h06;
  localparam reg_addr_t ADDR_COUNTER_RST  = 6'h07;
  localparam reg_addr_t ADDR_COUNTER_VAL  = 6'h08;
  localparam reg_addr_t ADDR_COUNTER_VALH = 6'h09;
  localparam reg_addr_t ADDR_IRQ_EN       = 6'h0A;
  localparam reg_addr_t ADDR_IRQ_STATUS   = 6'h0B;
  localparam reg_addr_t ADDR_DEAD_TIME    = 6'h0C;
  localparam reg_addr_t ADDR_VERSION      = 6'h0D;

endpackage

// File: rtl/regs_bus_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin, or requester 0 first when FIXED_PRIO is set.
// Grant is combinational; the fairness pointer only moves when update is high.
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic last_q;  // 1 = requester 1 won the previous grant

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (FIXED_PRIO || last_q) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (update && (req != 2'b00)) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/regs_bus_arbiter.sv
// Shares the PWM register-file byte bus between two requesters and adds
// atomic 16-bit accesses (LSB at addr, MSB at addr+1) under one grant.
module regs_bus_arbiter
  import regs_bus_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  wr0,
  input  logic                  wide0,
  input  logic [REG_ADDR_W-1:0] addr0,
  input  logic [15:0]           wdata0,
  output logic [15:0]           rdata0,
  output logic                  done0,
  input  logic                  req1,
  input  logic                  wr1,
  input  logic                  wide1,
  input  logic [REG_ADDR_W-1:0] addr1,
  input  logic [15:0]           wdata1,
  output logic [15:0]           rdata1,
  output logic                  done1,
  output logic                  read,
  output logic                  write,
  output logic [REG_ADDR_W-1:0] addr,
  output logic [REG_DATA_W-1:0] data_write,
  input  logic [REG_DATA_W-1:0] data_read
);

  bus_state_t state_q, state_d;
  logic       owner_q;
  logic       wr_q, wide_q;
  reg_addr_t  addr_q;
  logic [15:0] wdata_q, rdata_q, rdata0_q, rdata1_q, rdata_ack;
  logic [1:0] grant;

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({req1, req0}),
    .update (state_q == IDLE),
    .grant  (grant)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant != 2'b00) state_d = LO;
      LO:      state_d = wide_q ? HI : ACK;
      HI:      state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      wr_q     <= 1'b0;
      wide_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (grant != 2'b00) begin
          owner_q <= grant[1];
          wr_q    <= grant[1] ? wr1    : wr0;
          wide_q  <= grant[1] ? wide1  : wide0;
          addr_q  <= grant[1] ? addr1  : addr0;
          wdata_q <= grant[1] ? wdata1 : wdata0;
          rdata_q <= '0;
        end
        LO:  if (!wr_q) rdata_q[7:0]  <= data_read;
        HI:  if (!wr_q) rdata_q[15:8] <= data_read;
        ACK: if (owner_q) rdata1_q <= rdata_ack;
             else         rdata0_q <= rdata_ack;
        default: ;
      endcase
    end
  end

  // Owner sees the fresh value during ACK; the per-requester copy holds it afterwards.
  assign rdata_ack = wide_q ? rdata_q : {8'h00, rdata_q[7:0]};
  assign done0     = (state_q == ACK) && !owner_q;
  assign done1     = (state_q == ACK) &&  owner_q;
  assign rdata0    = done0 ? rdata_ack : rdata0_q;
  assign rdata1    = done1 ? rdata_ack : rdata1_q;

  // Bus side is decoded from flops only, never from the requester inputs.
  always_comb begin
    read       = 1'b0;
    write      = 1'b0;
    addr       = '0;
    data_write = '0;
    unique case (state_q)
      LO: begin
        read       = !wr_q;
        write      = wr_q;
        addr       = addr_q;
        data_write = wdata_q[7:0];
      end
      HI: begin
        read       = !wr_q;
        write      = wr_q;
        addr       = addr_q + reg_addr_t'(1);
        data_write = wdata_q[15:8];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regs_bus_arbiter.sv
// Directed self-checking bench for regs_bus_arbiter with a byte register-file model.
// A second FIXED_PRIO instance shares the request inputs for the priority test.
module tb_regs_bus_arbiter;
  import regs_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic req0, wr0, wide0, req1, wr1, wide1;
  logic [5:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [15:0] rdata0, rdata1, rdata0_fp, rdata1_fp;
  logic done0, done1, done0_fp, done1_fp;
  logic read, write, read_fp, write_fp;
  logic [5:0] addr, addr_fp;
  logic [7:0] data_write, data_write_fp, data_read;
  logic [7:0] mem [64];
  logic mem_clr;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regs_bus_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .wr0(wr0), .wide0(wide0), .addr0(addr0), .wdata0(wdata0),
    .rdata0(rdata0), .done0(done0),
    .req1(req1), .wr1(wr1), .wide1(wide1), .addr1(addr1), .wdata1(wdata1),
    .rdata1(rdata1), .done1(done1),
    .read(read), .write(write), .addr(addr), .data_write(data_write),
    .data_read(data_read)
  );

  regs_bus_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .wr0(wr0), .wide0(wide0), .addr0(addr0), .wdata0(wdata0),
    .rdata0(rdata0_fp), .done0(done0_fp),
    .req1(req1), .wr1(wr1), .wide1(wide1), .addr1(addr1), .wdata1(wdata1),
    .rdata1(rdata1_fp), .done1(done1_fp),
    .read(read_fp), .write(write_fp), .addr(addr_fp), .data_write(data_write_fp),
    .data_read(8'h00)
  );

  // Register-file model: combinational read, write on the strobe, held in reset too.
  assign data_read = mem[addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    end else if (write && rst_n) begin
      mem[addr] <= data_write;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered just after a rising edge with the DUT idle; leaves it idle the same way.
  task automatic txn(input bit r, input bit wr, input bit wide, input logic [5:0] a,
                     input logic [15:0] wd, input logic [15:0] exp_rd);
    logic [5:0] a_hi;
    a_hi = a + 6'd1;
    if (r) begin req1 = 1'b1; wr1 = wr; wide1 = wide; addr1 = a; wdata1 = wd; end
    else   begin req0 = 1'b1; wr0 = wr; wide0 = wide; addr0 = a; wdata0 = wd; end
    @(posedge clk); #1;
    // Scramble inputs after the grant; the bus must keep the captured values.
    if (r) begin wr1 = ~wr; wide1 = ~wide; addr1 = ~a; wdata1 = ~wd; end
    else   begin wr0 = ~wr; wide0 = ~wide; addr0 = ~a; wdata0 = ~wd; end
    @(negedge clk);
    check($sformatf("lo_write a=%0h", a), write, wr);
    check($sformatf("lo_read a=%0h", a), read, !wr);
    check($sformatf("lo_addr a=%0h", a), addr, a);
    if (wr) check($sformatf("lo_data a=%0h", a), data_write, wd[7:0]);
    check($sformatf("lo_done a=%0h", a), {done1, done0}, 2'b00);
    if (wide) begin
      @(negedge clk);
      check($sformatf("hi_write a=%0h", a), write, wr);
      check($sformatf("hi_addr a=%0h", a), addr, a_hi);
      if (wr) check($sformatf("hi_data a=%0h", a), data_write, wd[15:8]);
      check($sformatf("hi_done a=%0h", a), {done1, done0}, 2'b00);
    end
    @(negedge clk);
    check($sformatf("ack_done a=%0h", a), {done1, done0}, r ? 2'b10 : 2'b01);
    check($sformatf("ack_bus a=%0h", a), {read, write, addr, data_write}, 16'h0000);
    if (!wr) check($sformatf("ack_rdata a=%0h", a), r ? rdata1 : rdata0, exp_rd);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    check($sformatf("idle_done a=%0h", a), {done1, done0}, 2'b00);
    if (!wr) check($sformatf("hold_rdata a=%0h", a), r ? rdata1 : rdata0, exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_clr = 1'b1;
    req0 = 0; wr0 = 0; wide0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; wr1 = 0; wide1 = 0; addr1 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {done0, done1, read, write, addr, data_write}, 18'h0);
    check("reset_rdata", {rdata0, rdata1}, 32'h0);
    rst_n = 1'b1; mem_clr = 1'b0;
    @(posedge clk); #1;

    txn(1'b0, 1'b1, 1'b1, ADDR_PERIOD_L, 16'h1234, 16'h0);
    txn(1'b0, 1'b0, 1'b1, ADDR_PERIOD_L, 16'h0,    16'h1234);
    txn(1'b1, 1'b1, 1'b0, ADDR_IRQ_EN,   16'h0007, 16'h0);
    txn(1'b1, 1'b0, 1'b0, ADDR_IRQ_EN,   16'h0,    16'h0007);
    check("nonowner_rdata0", rdata0, 16'h1234);
    txn(1'b0, 1'b0, 1'b0, ADDR_PERIOD_H, 16'h0,    16'h0012);
    check("nonowner_rdata1", rdata1, 16'h0007);
    txn(1'b1, 1'b1, 1'b1, 6'h3F, 16'h5566, 16'h0);
    txn(1'b1, 1'b0, 1'b1, 6'h3F, 16'h0,    16'h5566);

    // Reset in the HI cycle of a wide write drops the transaction.
    req0 = 1'b1; wr0 = 1'b1; wide0 = 1'b1; addr0 = 6'h20; wdata0 = 16'hABCD;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_lo_write", {write, addr, data_write}, {1'b1, 6'h20, 8'hCD});
    @(negedge clk);
    check("rst_hi_addr", addr, 6'h21);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_outputs", {done0, done1, read, write, addr, data_write}, 18'h0);
    check("rst_mid_rdata", {rdata0, rdata1}, 32'h0);
    check("rst_lsb_written", mem[6'h20], 8'hCD);
    rst_n = 1'b1; req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_no_done%0d", i), {done0, done1, read, write}, 4'h0);
    end
    @(posedge clk); #1;

    // Both requesters held: round-robin alternates, fixed priority keeps requester 0.
    req0 = 1'b1; wr0 = 1'b0; wide0 = 1'b0; addr0 = ADDR_PERIOD_H; wdata0 = '0;
    req1 = 1'b1; wr1 = 1'b0; wide1 = 1'b0; addr1 = ADDR_IRQ_EN;   wdata1 = '0;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(done0 || done1) && n < 8);
      check($sformatf("rr_timeout%0d", k), (n < 8) ? 1 : 0, 1);
      check($sformatf("rr_owner%0d", k), {done1, done0}, (k % 2) ? 2'b10 : 2'b01);
      check($sformatf("fp_owner%0d", k), {done1_fp, done0_fp}, 2'b01);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/regs_bus_arbiter.md
Name: regs_bus_arbiter

Overview:
- Shares the single register-file bus (read/write/addr/data_write/data_read) of the PWM peripheral between two requesters, for example the SPI decoder and an on-chip config sequencer.
- Adds atomic 16-bit accesses: an LSB byte at addr, then an MSB byte at addr+1, in back-to-back cycles, with the grant held for the whole transaction.
- Sits between the requesters and the register file. Arbitration is round-robin, or fixed-priority when the parameter selects it.

Parameters:
- FIXED_PRIO, 0, 1 = requester 0 always wins a simultaneous request; 0 = round-robin.

Ports:
- clk  in  1  peripheral clock
- rst_n  in  1  synchronous active-low reset
- req0  in  1  requester 0 transaction request; held until done0
- wr0  in  1  1 = write, 0 = read
- wide0  in  1  1 = 16-bit access (addr, addr+1); 0 = single byte
- addr0  in  6  register address (LSB address for wide)
- wdata0  in  16  write data; [7:0] goes to addr, [15:8] to addr+1
- rdata0  out  16  read data; upper byte 0 for a narrow read
- done0  out  1  one-cycle completion pulse
- req1, wr1, wide1, addr1, wdata1, rdata1, done1: same as above, for requester 1
- read  out  1  register-file read strobe
- write  out  1  register-file write strobe
- addr  out  6  register-file address
- data_write  out  8  register-file write byte
- data_read  in  8  register-file read byte; combinational, valid in the same cycle as read

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE; rr pointer set so requester 0 has priority.
  - All outputs 0.
  - Any in-flight transaction is dropped with no done pulse. A wide write reset after its LSB cycle leaves the LSB written; this is accepted.
- FSM states: IDLE, LO, HI, ACK.
- IDLE:
  - If any req is high, grant one winner.
  - Capture its wr, wide, addr, wdata into internal flops and record the owner; go to LO.
  - Otherwise stay in IDLE.
- Arbitration (at the IDLE edge only):
  - Only one request: it wins.
  - Both requests, FIXED_PRIO=1: requester 0 wins.
  - Both requests, FIXED_PRIO=0: the requester not granted last wins. The pointer updates on grant.
- LO:
  - addr = captured addr; data_write = wdata[7:0].
  - write = wr_q; read = !wr_q.
  - On a read, data_read is captured into rdata_q[7:0].
  - Next state is HI if wide_q, else ACK.
- HI:
  - addr = captured addr + 1, 6-bit wrap (0x3F wraps to 0x00).
  - data_write = wdata[15:8]; strobes as in LO.
  - On a read, data_read is captured into rdata_q[15:8].
  - Next state is ACK.
- ACK:
  - done of the owner is high for exactly this cycle.
  - rdata of the owner = rdata_q, with [15:8] = 0 for narrow accesses.
  - No bus strobes. Next state is IDLE.
- Owner-side outputs:
  - rdata of the owner updates at ACK and then holds until that requester's next ACK.
  - The non-owner's rdata and done are unaffected.
- Bus outputs:
  - read, write, addr and data_write are decoded only from state flops and captured flops. No combinational path from req/addr/wdata inputs.
  - In IDLE and ACK: read = write = 0, addr = 0, data_write = 0.
- Latency, with req sampled in IDLE at edge T:
  - Narrow: bus cycle T+1, done at T+2.
  - Wide: bus cycles T+1 and T+2, done at T+3.
  - Minimum spacing between grants is 3 cycles (narrow) or 4 cycles (wide).
- Requester rules:
  - Inputs are sampled only at grant; changing them afterwards has no effect.
  - A requester must deassert req in the cycle after done, or present a new request. A req still high in IDLE after ACK is treated as a new transaction.
- A wide read of COUNTER_VAL (0x08) is two sequential byte reads with no snapshot; tearing is possible and out of scope.
- Writes to read-only or unmapped addresses are passed through unchanged; the register file ignores them.
- The COUNTER_RESET write (0x07) is passed through unchanged; its auto-clear is the register file's concern.

Decomposition:
- Shared package: state enum (IDLE, LO, HI, ACK), REG_ADDR_W = 6, REG_DATA_W = 8, and register address constants 0x00–0x0D.
- One sub-module is natural: rr_arb2, a 2-way round-robin arbiter with the FIXED_PRIO option and a grant-update enable.

Test Plan:
- req0 wide write addr=0x00 wdata=0x1234 → write at 0x00 data 0x34 at T+1, write at 0x01 data 0x12 at T+2, done0 at T+3; read-back of period = 0x1234.
- req1 narrow read addr=0x0A, with regs returning 0x07 → read strobe at T+1, done1 at T+2, rdata1 = 0x0007.
- req0 and req1 raised in the same cycle, both held, FIXED_PRIO=0 → grants alternate 0,1,0,1 over four transactions. With FIXED_PRIO=1 → requester 0 holds the bus while req0 stays high.
- Wide write addr=0x3F → second bus cycle at addr 0x00; done after 3 cycles.
- rst_n low during HI of a wide write → next cycle all outputs 0, no done pulse, state IDLE; LSB write already issued.
- wdata0 and addr0 changed after grant, mid-transaction → bus still carries the captured values.
